bcd_countdown_timer: RTL

//  Downstream consumer of the divided clock: MM:SS BCD countdown timer for the display path.

---
 rtl/bcd_countdown_timer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// MM:SS BCD countdown timer for the display path. It sits downstream of the
// clock divider. The divider's slow square wave (tick_in) is sampled as a
// plain data level on the fast system clock, and its rising edges are
// detected. A prescaler turns TICKS_PER_SEC rising edges into one 1 s strobe,
// and each strobe decrements the loaded MM:SS value by one second.
//
// Parameters
//   TICKS_PER_SEC  rising edges of tick_in per 1 s decrement (>= 1)
//   MAX_MIN        largest loadable minute value, decimal (<= 99)
//   PRE_W          prescaler width, 2**PRE_W > TICKS_PER_SEC-1
//
// Ports
//   clock     in   system clock, all logic on posedge
//   reset     in   synchronous active-high reset
//   tick_in   in   divided-clock level, synchronous to clock
//   start     in   request run (level)
//   stop      in   request pause / acknowledge done
//   load      in   load load_min/load_sec
//   load_min  in   BCD minutes {tens,units}
//   load_sec  in   BCD seconds {tens,units}
//   min_bcd   out  current minutes, BCD
//   sec_bcd   out  current seconds, BCD
//   running   out  high while counting (RUN)
//   done      out  high after expiry until stop or load (DONE)
//   expired   out  one-cycle pulse on the first cycle showing 00:00
//   load_err  out  one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned MAX_MIN       = 99,
    parameter int unsigned PRE_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
    localparam logic [7:0]       MAX_MIN_V = 8'(MAX_MIN);

    logic [1:0]       state;
    logic             tick_d;
    logic [PRE_W-1:0] prescaler;

    logic             tick_rise;
    logic             pre_last;
    logic             value_zero;
    logic             load_allowed;
    logic             load_valid;
    logic [7:0]       load_min_dec;
    logic [7:0]       dec_min;
    logic [7:0]       dec_sec;
    logic             dec_zero;

    assign tick_rise  = tick_in & ~tick_d;
    assign pre_last   = (prescaler == PRE_LAST);
    assign value_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    // A load is only considered outside RUN. The minute limit is checked on
    // the decimal value. An illegal nibble is rejected by the digit checks
    // regardless of how it compares here.
    assign load_allowed = (state != ST_RUN);
    assign load_min_dec = ({4'd0, load_min[7:4]} * 8'd10) + {4'd0, load_min[3:0]};
    assign load_valid   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                          (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                          (load_min_dec <= MAX_MIN_V);

    // One-second BCD decrement with borrow. The caller never applies this at
    // 00:00, because RUN is only entered with a non-zero value and is left
    // on reaching zero.
    always_comb begin
        dec_min = min_bcd;
        dec_sec = sec_bcd;
        if (sec_bcd[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_bcd[3:0] - 4'd1;
        end else if (sec_bcd[7:4] != 4'd0) begin
            dec_sec = {sec_bcd[7:4] - 4'd1, 4'd9};
        end else begin
            dec_sec = 8'h59;
            if (min_bcd[3:0] != 4'd0) begin
                dec_min[3:0] = min_bcd[3:0] - 4'd1;
            end else begin
                dec_min = {min_bcd[7:4] - 4'd1, 4'd9};
            end
        end
    end

    assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);

    // Control chain in priority order: load, stop, start, then the 1 s
    // strobe. A start that is seen in RUN or DONE has no effect, so it falls
    // through to the strobe. A load or stop in the same cycle suppresses both
    // the decrement and the prescaler advance, which keeps the phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            min_bcd   <= '0;
            sec_bcd   <= '0;
            expired   <= 1'b0;
            load_err  <= 1'b0;
            tick_d    <= 1'b0;
            prescaler <= '0;
        end else begin
            tick_d   <= tick_in;
            expired  <= 1'b0;
            load_err <= 1'b0;

            if (load) begin
                if (load_allowed && load_valid) begin
                    min_bcd   <= load_min;
                    sec_bcd   <= load_sec;
                    prescaler <= '0;
                    state     <= ST_IDLE;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (stop) begin
                if (state == ST_RUN) begin
                    state <= ST_PAUSE;
                end else if (state == ST_DONE) begin
                    state <= ST_IDLE;
                end
            end else if (start && ((state == ST_IDLE) || (state == ST_PAUSE))) begin
                if (!value_zero) begin
                    state <= ST_RUN;
                end
            end else if ((state == ST_RUN) && tick_rise) begin
                if (pre_last) begin
                    prescaler <= '0;
                    min_bcd   <= dec_min;
                    sec_bcd   <= dec_sec;
                    if (dec_zero) begin
                        state   <= ST_DONE;
                        expired <= 1'b1;
                    end
                end else begin
                    prescaler <= prescaler + PRE_ONE;
                end
            end
        end
    end

endmodule
